// File: rtl/ram_rd_pkg.sv
// Shared types and width helpers for the RAM read streamer and its output buffer.
package ram_rd_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 36;
    localparam int unsigned DEF_ADDR_WIDTH   = 14;
    localparam int unsigned DEF_READ_LATENCY = 11;
    localparam int unsigned DEF_BUF_DEPTH    = 16;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Bits needed to hold any value 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/stream_fifo_sync.sv
// Synchronous show-ahead FIFO: head word is visible on data_o whenever valid_o is high.
module stream_fifo_sync
    import ram_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_BUF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    // Pointer and occupancy update; pointers wrap at DEPTH, which need not be a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/ram_rd_streamer.sv
// Burst reader for one RAM port: issues credit-limited reads and streams the returned
// words out as valid/ready with a last marker and a completion pulse.
module ram_rd_streamer
    import ram_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
    parameter int unsigned BUF_DEPTH    = DEF_BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_dout_valid,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CW = cnt_width(BUF_DEPTH);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned LW = ADDR_WIDTH + 1;
    localparam int unsigned FW = cnt_width(READ_LATENCY);

    state_t                state_q, state_d;
    logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]         issued_q, issued_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         out_cnt_q, out_cnt_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic                  ram_en_q, ram_en_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  done_q, done_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;

    logic                  dv_acc;
    logic                  pop;
    logic                  accept;
    logic                  credit_nxt;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         buf_next;

    assign dv_acc = ram_dout_valid && (state_q != ST_FLUSH);
    assign pop    = m_valid && m_ready;
    assign accept = cmd_valid && cmd_ready_q;

    stream_fifo_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (dv_acc),
        .data_i  (ram_dout),
        .pop_i   (pop),
        .data_o  (m_data),
        .valid_o (m_valid),
        .count_o (fifo_count)
    );

    // ram_en is registered, so the credit test looks at next cycle's outstanding + occupancy.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        addr_d        = addr_q;
        issued_d      = issued_q;
        len_d         = len_q;
        out_cnt_d     = out_cnt_q;
        ram_en_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        done_d        = 1'b0;
        outstanding_d = outstanding_q + CW'(ram_en_q) - CW'(dv_acc);
        buf_next      = fifo_count + CW'(dv_acc) - CW'(pop);
        credit_nxt    = (SW'(outstanding_d) + SW'(buf_next)) < SW'(BUF_DEPTH);

        if (pop) begin
            out_cnt_d = out_cnt_q + LW'(1);
        end

        case (state_q)
            ST_FLUSH: begin
                outstanding_d = '0;
                flush_cnt_d   = flush_cnt_q + FW'(1);
                if (flush_cnt_q == FW'(READ_LATENCY - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_ISSUE;
                        len_d      = cmd_len;
                        out_cnt_d  = '0;
                        ram_en_d   = 1'b1;
                        ram_addr_d = cmd_addr;
                        addr_d     = cmd_addr + ADDR_WIDTH'(1);
                        issued_d   = LW'(1);
                    end
                end
            end
            ST_ISSUE: begin
                if (issued_q == len_q) begin
                    state_d = ST_DRAIN;
                end else if (credit_nxt) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = addr_q;
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    issued_d   = issued_q + LW'(1);
                end
            end
            ST_DRAIN: begin
                if (pop && m_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FLUSH;
            flush_cnt_q   <= '0;
            addr_q        <= '0;
            issued_q      <= '0;
            len_q         <= '0;
            out_cnt_q     <= '0;
            outstanding_q <= '0;
            ram_en_q      <= 1'b0;
            ram_addr_q    <= '0;
            done_q        <= 1'b0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            addr_q        <= addr_d;
            issued_q      <= issued_d;
            len_q         <= len_d;
            out_cnt_q     <= out_cnt_d;
            outstanding_q <= outstanding_d;
            ram_en_q      <= ram_en_d;
            ram_addr_q    <= ram_addr_d;
            done_q        <= done_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
        end
    end

    // Read data with nothing in flight means the RAM side broke its latency contract.
    assert property (@(posedge clk) disable iff (rst) !(dv_acc && (outstanding_q == '0)))
        else $error("ram_rd_streamer: ram_dout_valid with no read outstanding");

    assign cmd_ready = cmd_ready_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = 1'b0;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = '0;
    assign m_last    = m_valid && (out_cnt_q == (len_q - LW'(1)));
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
